// File: rtl/dsmod_fifo_pkg.sv
// Shared audio-path constants: sample FIFO geometry, level arithmetic and
// the delta-sigma modulator oversampling figures it is paired with.
package dsmod_fifo_pkg;

   // Sample FIFO defaults (signed two's complement samples)
   localparam int DSMOD_NBIT     = 30;
   localparam int DSMOD_AW       = 3;

   // Modulator oversampling ratio consumed alongside the FIFO
   localparam int DSMOD_OSR      = 64;
   localparam int DSMOD_OSR_LOG2 = 6;

   // Level counter needs one extra bit so that "full" (2**aw) is representable
   function automatic int lvl_width(input int aw);
      return aw + 1;
   endfunction

   // Per-cycle change applied to the stored-entry count
   typedef enum logic [1:0] {
      LVL_HOLD = 2'b00,
      LVL_INC  = 2'b01,
      LVL_DEC  = 2'b10
   } lvl_op_e;

endpackage

// File: rtl/dsmod_fifo.sv
// Sample FIFO feeding the delta-sigma modulator. The bus side pushes
// samples, the modulator pops one per data-read strobe and sees it on the
// registered o_data one cycle later. An empty pop holds the last sample so
// the output never clicks; error conditions are latched in sticky flags.
module dsmod_fifo
   import dsmod_fifo_pkg::*;
#(
   parameter int NBIT = DSMOD_NBIT,
   parameter int AW   = DSMOD_AW
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_wr_en,
   input  logic [NBIT-1:0]        i_wr_data,
   input  logic                   i_rd,
   output logic signed [NBIT-1:0] o_data,
   input  logic                   i_flush,
   input  logic [AW:0]            i_thresh,
   input  logic                   i_clr_err,
   output logic [AW:0]            o_level,
   output logic                   o_full,
   output logic                   o_empty,
   output logic                   o_irq_low,
   output logic                   o_underrun,
   output logic                   o_overflow
);

   localparam int            DEPTH   = 1 << AW;
   localparam int            LW      = lvl_width(AW);
   localparam logic [LW-1:0] DEPTH_L = DEPTH[LW-1:0];
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [LW-1:0] LVL_ONE = LW'(1);

   // Storage: flat register array, contents deliberately not reset
   logic [NBIT-1:0] mem_r [DEPTH];

   logic [AW-1:0]   wr_ptr_r, wr_ptr_s;
   logic [AW-1:0]   rd_ptr_r, rd_ptr_s;
   logic [LW-1:0]   level_r,  level_s;
   logic            full_r,   full_s;
   logic            empty_r,  empty_s;
   logic [NBIT-1:0] data_r,   data_s;
   logic            underrun_r, underrun_s;
   logic            overflow_r, overflow_s;

   logic            pop_ok_s;
   logic            push_ok_s;
   logic            und_evt_s;
   logic            ovf_evt_s;
   lvl_op_e         lvl_op_s;

   // Qualify requests against registered full/empty; flush masks everything
   always_comb begin
      pop_ok_s  = 1'b0;
      push_ok_s = 1'b0;
      und_evt_s = 1'b0;
      ovf_evt_s = 1'b0;
      if (i_flush) begin
         pop_ok_s  = 1'b0;
         push_ok_s = 1'b0;
         und_evt_s = 1'b0;
         ovf_evt_s = 1'b0;
      end else begin
         pop_ok_s  = i_rd & ~empty_r;
         // A full FIFO is never empty, so a pop while full always frees a slot
         push_ok_s = i_wr_en & (~full_r | pop_ok_s);
         und_evt_s = i_rd & empty_r;
         ovf_evt_s = i_wr_en & full_r & ~pop_ok_s;
      end
   end

   // Next-state for pointers, level, derived flags, output sample and errors
   always_comb begin
      wr_ptr_s   = wr_ptr_r;
      rd_ptr_s   = rd_ptr_r;
      level_s    = level_r;
      data_s     = data_r;
      lvl_op_s   = LVL_HOLD;

      case ({push_ok_s, pop_ok_s})
         2'b10:   lvl_op_s = LVL_INC;
         2'b01:   lvl_op_s = LVL_DEC;
         default: lvl_op_s = LVL_HOLD;
      endcase

      if (i_flush) begin
         wr_ptr_s = '0;
         rd_ptr_s = '0;
         level_s  = '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_s = wr_ptr_r;
         end
         if (pop_ok_s) begin
            rd_ptr_s = rd_ptr_r + PTR_ONE;
            data_s   = mem_r[rd_ptr_r];
         end else begin
            rd_ptr_s = rd_ptr_r;
            data_s   = data_r;
         end
         case (lvl_op_s)
            LVL_INC:  level_s = level_r + LVL_ONE;
            LVL_DEC:  level_s = level_r - LVL_ONE;
            LVL_HOLD: level_s = level_r;
            default:  level_s = level_r;
         endcase
      end

      full_s  = (level_s == DEPTH_L);
      empty_s = (level_s == '0);

      // Clear request yields to a new event in the same cycle
      underrun_s = (i_clr_err ? 1'b0 : underrun_r) | und_evt_s;
      overflow_s = (i_clr_err ? 1'b0 : overflow_r) | ovf_evt_s;
   end

   // Control state register with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         level_r    <= '0;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         data_r     <= '0;
         underrun_r <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_s;
         rd_ptr_r   <= rd_ptr_s;
         level_r    <= level_s;
         full_r     <= full_s;
         empty_r    <= empty_s;
         data_r     <= data_s;
         underrun_r <= underrun_s;
         overflow_r <= overflow_s;
      end
   end

   // Sample storage write; reset suppresses the store but does not clear it
   always_ff @(posedge i_clk) begin
      if (i_rst_n && push_ok_s) begin
         mem_r[wr_ptr_r] <= i_wr_data;
      end
   end

   assign o_data     = data_r;
   assign o_level    = level_r;
   assign o_full     = full_r;
   assign o_empty    = empty_r;
   assign o_irq_low  = (level_r <= i_thresh);
   assign o_underrun = underrun_r;
   assign o_overflow = overflow_r;

endmodule
